uop_instr_queue: RTL and testbench

- Circular FIFO of decoded micro-ops (uop_pkg::uop_insn, 144 bits) between the decoder/cracker and rename/ROB dispatch.
- Absorbs decode bursts and rename back-pressure.
- Supports a full pipeline flush on branch mispredict or exception.
- Blocks further enqueue once a UOP_HLT has been accepted, so nothing younger than the halt enters the backend.

---
 rtl/uop_pkg.sv | 36 +++
 rtl/uop_instr_queue_if.sv | 30 +++
 rtl/uop_instr_queue.sv | 98 +++++++++
 tb/tb_uop_instr_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Shared micro-op encoding for the decode -> rename path.
// A uop_insn is 144 bits: opcode, pc, immediate, register specifiers and flags.
package uop_pkg;

   localparam int INSTR_Q_DEPTH = 32;
   localparam int INSTR_Q_WIDTH = 5;

   typedef enum logic [7:0] {
      UOP_NOP   = 8'h00,
      UOP_ADD   = 8'h01,
      UOP_SUB   = 8'h02,
      UOP_AND   = 8'h03,
      UOP_OR    = 8'h04,
      UOP_XOR   = 8'h05,
      UOP_SHL   = 8'h06,
      UOP_SHR   = 8'h07,
      UOP_LOAD  = 8'h08,
      UOP_STORE = 8'h09,
      UOP_BR    = 8'h0A,
      UOP_JMP   = 8'h0B,
      UOP_CSR   = 8'h0C,
      UOP_FENCE = 8'h0D,
      UOP_HLT   = 8'hFF
   } uop_opcode_e;

   typedef struct packed {
      uop_opcode_e uopcode;
      logic [63:0] pc;
      logic [31:0] imm;
      logic [7:0]  rd;
      logic [7:0]  rs1;
      logic [7:0]  rs2;
      logic [15:0] flags;
   } uop_insn;

endpackage

// File: rtl/uop_instr_queue_if.sv
// Handshake bundle between the decoder (master) and the uop queue (slave),
// plus the dispatch-side handshake and queue status.
interface uop_instr_queue_if #(
   parameter int PTR_W = uop_pkg::INSTR_Q_WIDTH
);

   logic             flush_in;
   logic             enq_valid_in;
   uop_pkg::uop_insn enq_uop_in;
   logic             enq_ready_out;
   logic             deq_valid_out;
   uop_pkg::uop_insn deq_uop_out;
   logic             deq_ready_in;
   logic [PTR_W:0]   count_out;
   logic             almost_full_out;
   logic             halt_pending_out;

   modport master (
      output flush_in, enq_valid_in, enq_uop_in, deq_ready_in,
      input  enq_ready_out, deq_valid_out, deq_uop_out,
             count_out, almost_full_out, halt_pending_out
   );

   modport slave (
      input  flush_in, enq_valid_in, enq_uop_in, deq_ready_in,
      output enq_ready_out, deq_valid_out, deq_uop_out,
             count_out, almost_full_out, halt_pending_out
   );

endinterface

// File: rtl/uop_instr_queue.sv
// First-word fall-through circular queue of decoded uops with pipeline flush
// and a halt latch that stops enqueue once a UOP_HLT has been accepted.
module uop_instr_queue
   import uop_pkg::*;
#(
   parameter int DEPTH        = INSTR_Q_DEPTH,
   parameter int PTR_W        = INSTR_Q_WIDTH,
   parameter int AFULL_THRESH = 28
) (
   input logic              clk_in,
   input logic              rst_in,
   uop_instr_queue_if.slave q_if
);

   localparam logic [PTR_W:0] AFULL_CNT = AFULL_THRESH[PTR_W:0];
   localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           halt_q,   halt_d;
   uop_insn        mem_q [DEPTH];

   logic           empty;
   logic           full;
   logic           enq_ready;
   logic           enq_fire;
   logic           deq_fire;
   logic           is_hlt;
   logic [PTR_W:0] count;

   // Wrap bit (MSB) distinguishes full from empty when the indices match.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                  (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
      count     = wr_ptr_q - rd_ptr_q;
      enq_ready = !full && !halt_q;
      is_hlt    = (q_if.enq_uop_in.uopcode == UOP_HLT);
      enq_fire  = q_if.enq_valid_in && enq_ready && !q_if.flush_in;
      deq_fire  = !empty && q_if.deq_ready_in && !q_if.flush_in;
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      halt_d   = halt_q;
      if (q_if.flush_in) begin
         rd_ptr_d = wr_ptr_q;
         halt_d   = 1'b0;
      end else begin
         if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (is_hlt) begin
               halt_d = 1'b1;
            end
         end
         if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         halt_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         halt_q   <= halt_d;
      end
   end

   // NOTE: storage is not reset; empty pointers already mask stale contents, and a resettable array costs a mux per bit.
   always_ff @(posedge clk_in) begin
      if (enq_fire && !rst_in) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= q_if.enq_uop_in;
      end
   end

   assign q_if.enq_ready_out    = enq_ready;
   assign q_if.deq_valid_out    = !empty;
   assign q_if.deq_uop_out      = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign q_if.count_out        = count;
   assign q_if.almost_full_out  = (count >= AFULL_CNT);
   assign q_if.halt_pending_out = halt_q;

   a_count_bound : assert property (@(posedge clk_in) disable iff (rst_in)
      count <= DEPTH_CNT);

   a_no_enq_when_full : assert property (@(posedge clk_in) disable iff (rst_in)
      full |-> !enq_fire);

endmodule

// File: tb/tb_uop_instr_queue.sv
// Directed bench for uop_instr_queue: stimulus pushes expected uops into a
// scoreboard, a negedge monitor pops and compares on every dequeue.
module tb_uop_instr_queue;
   import uop_pkg::*;

   logic    clk_in = 1'b0;
   logic    rst_in;
   int      checks = 0;
   int      errors = 0;
   uop_insn exp_q [$];

   uop_instr_queue_if q_if ();

   uop_instr_queue dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .q_if   (q_if)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic uop_insn mk(input uop_opcode_e op, input int pc);
      uop_insn u;
      u.uopcode = op;
      u.pc      = 64'(pc);
      u.imm     = 32'(pc * 7 + 3);
      u.rd      = 8'(pc);
      u.rs1     = 8'(pc + 1);
      u.rs2     = 8'(pc + 2);
      u.flags   = 16'(pc) ^ 16'h5A5A;
      return u;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic enq(input uop_insn u);
      q_if.enq_valid_in = 1'b1;
      q_if.enq_uop_in   = u;
      exp_q.push_back(u);
      tick();
      q_if.enq_valid_in = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      q_if.deq_ready_in = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      q_if.deq_ready_in = 1'b0;
      check({name, "_remaining"}, exp_q.size(), 0);
      check({name, "_deq_valid"}, q_if.deq_valid_out, 1'b0);
      check({name, "_count"}, q_if.count_out, 0);
   endtask

   // Scoreboard monitor: a dequeue fires at the next posedge when this holds.
   initial begin
      forever begin
         @(negedge clk_in);
         if (!rst_in && !q_if.flush_in && q_if.deq_valid_out && q_if.deq_ready_in) begin
            if (exp_q.size() == 0) begin
               check("deq_unexpected", q_if.deq_valid_out, 1'b0);
            end else begin
               check("deq_uop", q_if.deq_uop_out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_in            = 1'b1;
      q_if.flush_in     = 1'b0;
      q_if.enq_valid_in = 1'b0;
      q_if.enq_uop_in   = '0;
      q_if.deq_ready_in = 1'b0;
      tick();
      tick();
      rst_in = 1'b0;
      check("rst_count", q_if.count_out, 0);
      check("rst_deq_valid", q_if.deq_valid_out, 1'b0);
      check("rst_afull", q_if.almost_full_out, 1'b0);
      check("rst_halt", q_if.halt_pending_out, 1'b0);
      check("rst_enq_ready", q_if.enq_ready_out, 1'b1);

      // Three back-to-back enqueues, no dequeue.
      enq(mk(UOP_ADD, 32'h100));
      enq(mk(UOP_SUB, 32'h104));
      enq(mk(UOP_LOAD, 32'h108));
      check("t1_count", q_if.count_out, 3);
      check("t1_head_op", q_if.deq_uop_out.uopcode, UOP_ADD);
      check("t1_afull", q_if.almost_full_out, 1'b0);
      drain("t1");

      // Fill to DEPTH; almost_full from the 28th entry on.
      for (int k = 1; k <= 32; k++) begin
         enq(mk(UOP_ADD, k - 1));
         check($sformatf("fill_count_%0d", k), q_if.count_out, k);
         check($sformatf("fill_afull_%0d", k), q_if.almost_full_out, 1'(k >= 28));
      end
      check("full_enq_ready", q_if.enq_ready_out, 1'b0);
      q_if.enq_valid_in = 1'b1;
      q_if.enq_uop_in   = mk(UOP_SUB, 99);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("full_hold_count_%0d", k), q_if.count_out, 32);
      end
      q_if.enq_valid_in = 1'b0;
      drain("fill");

      // 30 entries, then 40 cycles of concurrent enqueue/dequeue across the wrap.
      for (int k = 0; k < 30; k++) begin
         enq(mk(UOP_XOR, 200 + k));
      end
      q_if.deq_ready_in = 1'b1;
      for (int k = 0; k < 40; k++) begin
         q_if.enq_valid_in = 1'b1;
         q_if.enq_uop_in   = mk(UOP_OR, 230 + k);
         exp_q.push_back(q_if.enq_uop_in);
         tick();
         check($sformatf("wrap_count_%0d", k), q_if.count_out, 30);
      end
      q_if.enq_valid_in = 1'b0;
      drain("wrap");

      // Halt blocks younger uops; the halt and older entries still drain.
      enq(mk(UOP_ADD, 300));
      enq(mk(UOP_HLT, 301));
      check("hlt_pending", q_if.halt_pending_out, 1'b1);
      check("hlt_enq_ready", q_if.enq_ready_out, 1'b0);
      q_if.enq_valid_in = 1'b1;
      q_if.enq_uop_in   = mk(UOP_SUB, 302);
      tick();
      tick();
      check("hlt_count", q_if.count_out, 2);
      drain("hlt");
      q_if.enq_valid_in = 1'b0;
      check("hlt_still_pending", q_if.halt_pending_out, 1'b1);

      // Clear the halt, build 10 entries ending in a HLT, then flush with both handshakes offered.
      q_if.flush_in = 1'b1;
      tick();
      q_if.flush_in = 1'b0;
      check("clr_halt", q_if.halt_pending_out, 1'b0);
      check("clr_enq_ready", q_if.enq_ready_out, 1'b1);
      for (int k = 0; k < 9; k++) begin
         enq(mk(UOP_STORE, 400 + k));
      end
      enq(mk(UOP_HLT, 409));
      check("pre_flush_count", q_if.count_out, 10);
      check("pre_flush_halt", q_if.halt_pending_out, 1'b1);
      q_if.flush_in     = 1'b1;
      q_if.enq_valid_in = 1'b1;
      q_if.enq_uop_in   = mk(UOP_ADD, 999);
      q_if.deq_ready_in = 1'b1;
      exp_q.delete();
      tick();
      q_if.flush_in     = 1'b0;
      q_if.enq_valid_in = 1'b0;
      q_if.deq_ready_in = 1'b0;
      check("flush_count", q_if.count_out, 0);
      check("flush_deq_valid", q_if.deq_valid_out, 1'b0);
      check("flush_halt", q_if.halt_pending_out, 1'b0);
      check("flush_enq_ready", q_if.enq_ready_out, 1'b1);
      enq(mk(UOP_BR, 500));
      check("post_flush_count", q_if.count_out, 1);
      drain("flush");

      // Reset dominates flush and enqueue mid-operation.
      for (int k = 0; k < 16; k++) begin
         enq(mk(UOP_SHL, 600 + k));
      end
      enq(mk(UOP_HLT, 616));
      check("pre_rst_count", q_if.count_out, 17);
      rst_in            = 1'b1;
      q_if.flush_in     = 1'b1;
      q_if.enq_valid_in = 1'b1;
      q_if.enq_uop_in   = mk(UOP_ADD, 777);
      exp_q.delete();
      tick();
      rst_in            = 1'b0;
      q_if.flush_in     = 1'b0;
      q_if.enq_valid_in = 1'b0;
      check("mid_rst_count", q_if.count_out, 0);
      check("mid_rst_deq_valid", q_if.deq_valid_out, 1'b0);
      check("mid_rst_afull", q_if.almost_full_out, 1'b0);
      check("mid_rst_halt", q_if.halt_pending_out, 1'b0);
      check("mid_rst_enq_ready", q_if.enq_ready_out, 1'b1);
      enq(mk(UOP_LOAD, 800));
      check("post_rst_count", q_if.count_out, 1);
      check("post_rst_head_pc", q_if.deq_uop_out.pc, 64'd800);
      drain("rst");

      tick();
      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
